// File: rtl/fft_frame_loader.sv
// fft_frame_loader
// Collects a serial stream of complex samples into N-sample frames and hands
// each completed frame to the FFT core in parallel. The fill buffer and the
// output bus registers form a double buffer, so the next frame streams in
// while the core works on the current one.
module fft_frame_loader #(
   parameter int N = 32,
   parameter int W = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [W-1:0]     s_re,
   input  logic [W-1:0]     s_im,
   input  logic             s_last,
   output logic [N*W-1:0]   r_bus,
   output logic [N*W-1:0]   i_bus,
   output logic             enable,
   input  logic             ret,
   output logic             frame_err,
   output logic [15:0]      frame_cnt
);

   localparam int IW = $clog2(N);
   localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t r_state;
   state_t w_nextState;

   logic [W-1:0]   r_fillRe [N];
   logic [W-1:0]   r_fillIm [N];
   logic [IW-1:0]  r_wrIdx;
   logic           r_fillFull;
   logic           r_frameErr;
   logic           r_retQ;
   logic [15:0]    r_frameCnt;
   logic [N*W-1:0] r_rBus;
   logic [N*W-1:0] r_iBus;

   logic w_accept;
   logic w_atLast;
   logic w_goodLast;
   logic w_misalign;
   logic w_write;
   logic w_retRise;
   logic w_load;

   // The loader refuses samples while a completed frame waits for the core,
   // and also while reset is held so nothing is accepted during reset.
   assign s_ready    = ~r_fillFull & ~rst;
   assign w_accept   = s_valid & s_ready;
   assign w_atLast   = (r_wrIdx == LAST_IDX);
   assign w_goodLast = w_accept & s_last & w_atLast;
   // A frame is misaligned when s_last and the final slot do not coincide;
   // the offending sample is thrown away along with the partial frame.
   assign w_misalign = w_accept & (s_last ^ w_atLast);
   assign w_write    = w_accept & ~w_misalign;
   assign w_retRise  = ret & ~r_retQ;

   assign r_bus     = r_rBus;
   assign i_bus     = r_iBus;
   assign enable    = (r_state == RUN);
   assign frame_err = r_frameErr;
   assign frame_cnt = r_frameCnt;

   // Sample storage needs no reset: a stale slot is always overwritten
   // before the frame it belongs to can be marked full.
   always_ff @(posedge clk) begin
      if (w_write) begin
         r_fillRe[r_wrIdx] <= s_re;
         r_fillIm[r_wrIdx] <= s_im;
      end
   end

   // Write index, frame-full flag and the misalignment pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wrIdx    <= '0;
         r_fillFull <= 1'b0;
         r_frameErr <= 1'b0;
      end else begin
         r_frameErr <= w_misalign;
         if (w_accept) begin
            if (w_goodLast || w_misalign) begin
               r_wrIdx <= '0;
            end else begin
               r_wrIdx <= r_wrIdx + IW'(1);
            end
         end
         if (w_goodLast) begin
            r_fillFull <= 1'b1;
         end else if (w_load) begin
            r_fillFull <= 1'b0;
         end
      end
   end

   // Delayed copy of ret so only a fresh low-to-high edge counts as done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_retQ <= 1'b0;
      end else begin
         r_retQ <= ret;
      end
   end

   // Controller state register; reset drops enable immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next state and LOAD decision. LOAD only happens from IDLE, which is
   // what keeps the bus stable for the whole time enable is high.
   always_comb begin
      w_nextState = r_state;
      w_load      = 1'b0;
      case (r_state)
         IDLE: begin
            if (r_fillFull) begin
               w_load      = 1'b1;
               w_nextState = RUN;
            end
         end
         RUN: begin
            if (w_retRise) begin
               w_nextState = IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Parallel output registers and the dispatched-frame counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rBus     <= '0;
         r_iBus     <= '0;
         r_frameCnt <= '0;
      end else if (w_load) begin
         for (int k = 0; k < N; k++) begin
            r_rBus[k*W +: W] <= r_fillRe[k];
            r_iBus[k*W +: W] <= r_fillIm[k];
         end
         r_frameCnt <= r_frameCnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_fft_frame_loader.sv
// tb_fft_frame_loader
// Drives whole frames into the loader, plays the part of the FFT core on ret,
// and matches every dispatched frame against a queue of expected frames.
module tb_fft_frame_loader;

   localparam int N = 32;
   localparam int W = 12;
   localparam int BW = N * W;

   logic          clk;
   logic          rst;
   logic          s_valid;
   logic          s_ready;
   logic [W-1:0]  s_re;
   logic [W-1:0]  s_im;
   logic          s_last;
   logic [BW-1:0] r_bus;
   logic [BW-1:0] i_bus;
   logic          enable;
   logic          ret;
   logic          frame_err;
   logic [15:0]   frame_cnt;

   int totalChecks = 0;
   int passedChecks = 0;
   int errPulses = 0;
   logic [15:0] expCnt = 16'd0;
   logic prevEn = 1'b0;

   logic [W-1:0]  fRe [N];
   logic [W-1:0]  fIm [N];
   logic [BW-1:0] expR [$];
   logic [BW-1:0] expI [$];
   logic [BW-1:0] frameAR;
   logic [W-1:0]  c12;

   fft_frame_loader #(.N(N), .W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_re      (s_re),
      .s_im      (s_im),
      .s_last    (s_last),
      .r_bus     (r_bus),
      .i_bus     (i_bus),
      .enable    (enable),
      .ret       (ret),
      .frame_err (frame_err),
      .frame_cnt (frame_cnt)
   );

   // Free-running 100 MHz clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case a sequence deadlocks.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point for every check in the bench.
   task automatic checkOutput(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
      totalChecks++;
      if (obs === exp) begin
         passedChecks++;
      end else begin
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [BW-1:0] packRe();
      logic [BW-1:0] b;
      b = '0;
      for (int k = 0; k < N; k++) b[k*W +: W] = fRe[k];
      return b;
   endfunction

   function automatic logic [BW-1:0] packIm();
      logic [BW-1:0] b;
      b = '0;
      for (int k = 0; k < N; k++) b[k*W +: W] = fIm[k];
      return b;
   endfunction

   task automatic newFrame();
      for (int k = 0; k < N; k++) begin
         fRe[k] = W'($urandom);
         fIm[k] = W'($urandom);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Presents one sample and returns #1 after the edge that accepts it.
   task automatic sendSample(input logic [W-1:0] re, input logic [W-1:0] im, input logic last);
      int guard;
      guard = 0;
      s_valid = 1'b1;
      s_re    = re;
      s_im    = im;
      s_last  = last;
      while (!s_ready && guard < 2000) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (guard >= 2000) checkOutput("acceptTimeout", BW'(s_ready), BW'(1));
      @(posedge clk);
      #1;
   endtask

   // Streams the current frame buffer; aligned frames are queued as expected dispatches.
   task automatic applyStimulus(input int nSamples, input int lastPos, input bit pushExp);
      if (pushExp) begin
         expR.push_back(packRe());
         expI.push_back(packIm());
      end
      for (int j = 0; j < nSamples; j++) begin
         sendSample(fRe[j], fIm[j], (j == lastPos));
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   // One-cycle ret pulse followed by a low cycle so the next pulse is a new edge.
   task automatic pulseRet();
      ret = 1'b1;
      @(posedge clk);
      #1;
      ret = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // Scoreboard side: every rising edge of enable must match the oldest queued frame.
   always @(negedge clk) begin
      logic [BW-1:0] er;
      logic [BW-1:0] ei;
      if (frame_err) errPulses++;
      if (enable && !prevEn) begin
         if (expR.size() == 0) begin
            checkOutput("unexpectedDispatch", BW'(1), BW'(0));
         end else begin
            er = expR.pop_front();
            ei = expI.pop_front();
            expCnt = expCnt + 16'd1;
            checkOutput("dispatchRe", r_bus, er);
            checkOutput("dispatchIm", i_bus, ei);
            checkOutput("dispatchCnt", BW'(frame_cnt), BW'(expCnt));
         end
      end
      prevEn = enable;
   end

   initial begin
      int guard;
      rst = 1'b1;
      s_valid = 1'b0;
      s_re = '0;
      s_im = '0;
      s_last = 1'b0;
      ret = 1'b0;
      waitCycles(2);
      checkOutput("rstReady", BW'(s_ready), BW'(0));
      checkOutput("rstEnable", BW'(enable), BW'(0));
      checkOutput("rstRbus", r_bus, '0);
      checkOutput("rstIbus", i_bus, '0);
      checkOutput("rstCnt", BW'(frame_cnt), BW'(0));
      checkOutput("rstErr", BW'(frame_err), BW'(0));
      rst = 1'b0;
      #1;
      checkOutput("readyAfterRst", BW'(s_ready), BW'(1));
      waitCycles(1);

      // Reset in the middle of a fill at index 17
      newFrame();
      applyStimulus(17, -1, 1'b0);
      rst = 1'b1;
      #1;
      checkOutput("midRstReady", BW'(s_ready), BW'(0));
      checkOutput("midRstEnable", BW'(enable), BW'(0));
      checkOutput("midRstRbus", r_bus, '0);
      waitCycles(2);
      rst = 1'b0;
      waitCycles(1);
      checkOutput("midRstCnt", BW'(frame_cnt), BW'(0));

      // Frame A with known values; must start at index 0 after the reset
      newFrame();
      fRe[0] = 12'd0;
      fRe[1] = -12'sd1700;
      fRe[31] = 12'sd1502;
      fIm[0] = -12'sd1884;
      fIm[31] = 12'sd2032;
      frameAR = packRe();
      applyStimulus(32, 31, 1'b1);
      checkOutput("fullNotReady", BW'(s_ready), BW'(0));
      waitCycles(1);
      checkOutput("aEnable", BW'(enable), BW'(1));
      checkOutput("aR0", BW'(r_bus[11:0]), BW'(0));
      c12 = -12'sd1700;
      checkOutput("aR1", BW'(r_bus[23:12]), BW'(c12));
      c12 = 12'sd2032;
      checkOutput("aI31", BW'(i_bus[383:372]), BW'(c12));
      checkOutput("aCnt", BW'(frame_cnt), BW'(1));

      // Frame B fills while A runs; A must stay on the bus until ret
      newFrame();
      fRe[0] = 12'sd1536;
      fIm[0] = -12'sd1427;
      applyStimulus(32, 31, 1'b1);
      checkOutput("bFullNotReady", BW'(s_ready), BW'(0));
      waitCycles(2);
      checkOutput("aHeld", r_bus, frameAR);
      ret = 1'b1;
      waitCycles(1);
      checkOutput("gapLow", BW'(enable), BW'(0));
      ret = 1'b0;
      waitCycles(1);
      checkOutput("gapHigh", BW'(enable), BW'(1));
      c12 = 12'sd1536;
      checkOutput("bR0", BW'(r_bus[11:0]), BW'(c12));
      checkOutput("bCnt", BW'(frame_cnt), BW'(2));

      // Backpressure: C fills, D waits with valid held until C is loaded
      newFrame();
      applyStimulus(32, 31, 1'b1);
      checkOutput("bpReadyLow", BW'(s_ready), BW'(0));
      newFrame();
      fork
         applyStimulus(32, 31, 1'b1);
         begin
            waitCycles(4);
            checkOutput("bpStillLow", BW'(s_ready), BW'(0));
            ret = 1'b1;
            waitCycles(1);
            ret = 1'b0;
            waitCycles(1);
            checkOutput("bpEnable", BW'(enable), BW'(1));
            checkOutput("bpReadyBack", BW'(s_ready), BW'(1));
            checkOutput("bpCnt", BW'(frame_cnt), BW'(3));
         end
      join
      waitCycles(2);
      pulseRet();
      pulseRet();
      checkOutput("dDone", BW'(enable), BW'(0));

      // Misalignment: s_last on sample 20
      newFrame();
      applyStimulus(21, 20, 1'b0);
      waitCycles(3);
      checkOutput("earlyLastErr", BW'(errPulses), BW'(1));
      checkOutput("earlyLastNoRun", BW'(enable), BW'(0));
      checkOutput("earlyLastCnt", BW'(frame_cnt), BW'(4));
      newFrame();
      applyStimulus(32, 31, 1'b1);
      waitCycles(2);
      pulseRet();

      // Misalignment: sample 31 arrives without s_last
      newFrame();
      applyStimulus(32, -1, 1'b0);
      waitCycles(3);
      checkOutput("missingLastErr", BW'(errPulses), BW'(2));
      checkOutput("missingLastNoRun", BW'(enable), BW'(0));
      newFrame();
      applyStimulus(32, 31, 1'b1);
      waitCycles(2);
      checkOutput("fCnt", BW'(frame_cnt), BW'(6));

      // ret held high for 5 cycles completes only one frame
      newFrame();
      applyStimulus(32, 31, 1'b1);
      waitCycles(1);
      ret = 1'b1;
      waitCycles(5);
      checkOutput("heldRetEnable", BW'(enable), BW'(1));
      checkOutput("heldRetCnt", BW'(frame_cnt), BW'(7));
      ret = 1'b0;
      waitCycles(1);
      pulseRet();
      checkOutput("gDone", BW'(enable), BW'(0));

      // ret pulse while idle has no effect
      pulseRet();
      waitCycles(2);
      checkOutput("idleRetEnable", BW'(enable), BW'(0));
      checkOutput("idleRetCnt", BW'(frame_cnt), BW'(7));
      newFrame();
      applyStimulus(32, 31, 1'b1);
      waitCycles(2);
      checkOutput("hCnt", BW'(frame_cnt), BW'(8));

      guard = 0;
      while (expR.size() != 0 && guard < 100) begin
         waitCycles(1);
         guard++;
      end
      checkOutput("queueEmpty", BW'(expR.size()), BW'(0));
      checkOutput("errTotal", BW'(errPulses), BW'(2));

      $display("%0d/%0d checks passed", passedChecks, totalChecks);
      $finish;
   end

endmodule
